fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame; also the FIFO word width.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range >= 2.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  permits starting a new frame; does not affect a frame in progress.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_data  input  WIDTH  FIFO registered output word.
REQ-008 fifo_pop  output  1  one-cycle pop request to the FIFO.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  high from pop cycle through the last stop-bit cycle.

Function
REQ-011 The state machine SHALL have the states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE -> POP when enable && !fifo_empty.
- POP -> LOAD unconditionally.
- LOAD -> START.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> PARITY or STOP after WIDTH bits.
- PARITY -> STOP.
- STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-012 fifo_pop SHALL be high for exactly the single POP cycle and never in any other state.
REQ-013 fifo_pop SHALL never be asserted while fifo_empty is high in the same cycle.
REQ-014 In LOAD, the block SHALL capture fifo_data into the shift register; FIFO data_out is valid one cycle after the pop edge.
REQ-015 tx SHALL be 0 for the START bit; DATA bits SHALL go out LSB first; tx SHALL be 1 in STOP, IDLE, POP and LOAD.
REQ-016 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a bit counter of width $clog2(CLKS_PER_BIT) and a data-bit index of width $clog2(WIDTH)+1.
REQ-017 The frame SHALL start with tx low on the first cycle after LOAD; frame length SHALL be (WIDTH+2)*CLKS_PER_BIT cycles, or (WIDTH+3)*CLKS_PER_BIT cycles with parity.
REQ-018 Back-to-back frames: STOP's last cycle -> IDLE -> POP, giving a minimum gap of 3 idle-high cycles between stop and the next start.
REQ-019 Deasserting enable mid-frame SHALL let the current frame complete; no new pop SHALL occur until enable is high again.
REQ-020 fifo_empty rising mid-frame SHALL have no effect on the current frame.
REQ-021 busy SHALL be low only in IDLE.

Reset
REQ-022 While reset is high at a clock edge: state <= IDLE, tx <= 1, fifo_pop <= 0, busy <= 0, counters <= 0, shift register <= 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the next edge, and no pop SHALL occur during reset.
REQ-024 The first pop after reset release SHALL occur no earlier than the second edge after reset deasserts.

Configuration
REQ-025 Macro UART_TX_PARITY_EN:
- Defined: the PARITY state SHALL be inserted after DATA, sending the even-parity bit (XOR of the captured word) for CLKS_PER_BIT cycles.
- Undefined: the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification (CLKS_PER_BIT=4, WIDTH=8)
REQ-026 Reset held 3 cycles with fifo_empty=0, enable=1 -> fifo_pop=0, tx=1, busy=0 throughout.
REQ-027 Single word 0xA5, parity off -> one pop pulse; tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; 40 cycles from start to idle; busy falls after stop.
REQ-028 Same word 0xA5 with UART_TX_PARITY_EN -> parity bit 0 inserted before stop; frame 44 cycles. Word 0x07 -> parity bit 1.
REQ-029 FIFO holding 0x01, 0xFF with enable=1 -> two pops exactly 43 cycles apart; second frame data bits all 1.
REQ-030 enable dropped at the third data bit of 0x3C -> frame completes intact; no further pop while enable=0; pop occurs 2 cycles after enable returns to 1.
REQ-031 reset pulsed for 1 cycle during the fifth data bit -> tx=1 on the next cycle and state IDLE; a new pop on the following cycles if fifo_empty=0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that pops words from a FIFO and frames them.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH) + 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd6;
`endif

  logic [2:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign bit_end = (bit_cnt == BIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && !fifo_empty) state <= S_POP;
        end
        S_POP: begin
          state <= S_LOAD;
        end
        // FIFO output register is valid one cycle after the pop edge
        S_LOAD: begin
          shreg   <= fifo_data;
          bit_cnt <= '0;
          bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^fifo_data;
`endif
          state   <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state, so reset forces idle values on the next edge
  always_comb begin
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = parity_bit;
`endif
      default:  tx = 1'b1;
    endcase
  end

  assign fifo_pop = (state == S_POP) && !fifo_empty;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx (WIDTH=8, CLKS_PER_BIT=4).
module tb_fifo_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = W + 3;
`else
  localparam int NBITS = W + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_pop;
  logic         tx;
  logic         busy;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model: registered output word, updated on the pop edge
  logic [W-1:0] mem [0:63];
  int n_push = 0;
  int n_pop  = 0;
  assign fifo_empty = (n_push == n_pop);

  always @(posedge clock) begin
    if (fifo_pop) begin
      fifo_data <= mem[n_pop[5:0]];
      n_pop     <= n_pop + 1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [W-1:0] exp_q [$];
  int           pop_cycs [$];
  int           pop_cnt = 0;
  int           last_pop_cyc = 0;
  logic         prev_pop = 1'b0;
  logic         mon_en = 1'b1;
  int           frames_done = 0;

  task automatic push_word(input logic [W-1:0] w, input bit track);
    mem[n_push[5:0]] = w;
    n_push++;
    if (track) exp_q.push_back(w);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (fifo_pop) begin
        check_eq("pop_width", {31'd0, prev_pop}, 0);
        check_eq("pop_nonempty", {31'd0, fifo_empty}, 0);
        last_pop_cyc = cyc;
        pop_cycs.push_back(cyc);
        pop_cnt++;
      end
      prev_pop = fifo_pop;
    end
  end

  // Frame monitor: expects every bit held CPB cycles, then idle after stop
  initial begin
    logic [W-1:0] w;
    logic         eb;
    logic         gb;
    logic         bz;
    forever begin
      @(negedge clock);
      if (mon_en && !reset && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check_eq("start_latency", cyc - last_pop_cyc, 2);
          for (int k = 0; k < NBITS; k++) begin
            if (k == 0)           eb = 1'b0;
            else if (k <= W)      eb = w[k-1];
            else if (k == W + 1 && NBITS == W + 3) eb = ^w;
            else                  eb = 1'b1;
            gb = eb;
            bz = 1'b1;
            for (int c = 0; c < CPB; c++) begin
              if (k > 0 || c > 0) @(negedge clock);
              if (tx !== eb) gb = tx;
              if (busy !== 1'b1) bz = 1'b0;
            end
            check_eq($sformatf("frame_%0h_bit%0d", w, k), {31'd0, gb}, {31'd0, eb});
            check_eq("busy_in_frame", {31'd0, bz}, 1);
          end
          @(negedge clock);
          check_eq("busy_after_stop", {31'd0, busy}, 0);
          check_eq("tx_after_stop", {31'd0, tx}, 1);
          frames_done++;
        end
      end
    end
  end

  task automatic wait_pops(input int n, input int limit);
    int t = 0;
    while (pop_cnt < n && t < limit) begin
      tick();
      t++;
    end
    if (pop_cnt < n) check_eq("pop_timeout", pop_cnt, n);
  endtask

  task automatic wait_frames(input int n, input int limit);
    int t = 0;
    while (frames_done < n && t < limit) begin
      tick();
      t++;
    end
    if (frames_done < n) check_eq("frame_timeout", frames_done, n);
  endtask

  initial begin
    int rel_cyc;
    int lat;
    reset  = 1'b1;
    enable = 1'b1;
    push_word(8'hA5, 1'b1);

    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_pop", {31'd0, fifo_pop}, 0);
      check_eq("rst_tx", {31'd0, tx}, 1);
      check_eq("rst_busy", {31'd0, busy}, 0);
    end
    reset   = 1'b0;
    rel_cyc = cyc;
    wait_pops(1, 20);
    lat = last_pop_cyc - rel_cyc;
    check_eq("first_pop_latency_ok", {31'd0, (lat >= 1 && lat <= 2)}, 1);
    wait_frames(1, 300);
    check_eq("single_pop_count", pop_cnt, 1);

    push_word(8'h01, 1'b1);
    push_word(8'hFF, 1'b1);
    wait_frames(3, 400);
    check_eq("b2b_pop_count", pop_cnt, 3);
    if (pop_cycs.size() >= 3) check_eq("b2b_pop_gap", pop_cycs[2] - pop_cycs[1], FRAME + 3);

    push_word(8'h3C, 1'b1);
    wait_pops(4, 20);
    while (cyc < last_pop_cyc + 14) tick();
    enable = 1'b0;
    push_word(8'h5A, 1'b1);
    wait_frames(4, 300);
    repeat (20) tick();
    check_eq("no_pop_while_disabled", pop_cnt, 4);
    enable  = 1'b1;
    rel_cyc = cyc;
    wait_pops(5, 10);
    lat = last_pop_cyc - rel_cyc;
    check_eq("enable_pop_latency_ok", {31'd0, (lat >= 1 && lat <= 2)}, 1);
    wait_frames(5, 300);

    mon_en = 1'b0;
    push_word(8'h81, 1'b0);
    wait_pops(6, 20);
    while (cyc < last_pop_cyc + 22) tick();
    check_eq("pre_abort_busy", {31'd0, busy}, 1);
    push_word(8'h07, 1'b1);
    reset = 1'b1;
    tick();
    check_eq("abort_tx", {31'd0, tx}, 1);
    check_eq("abort_idle", {31'd0, busy}, 0);
    check_eq("abort_no_pop", pop_cnt, 6);
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_pops(7, 10);
    wait_frames(6, 300);
    check_eq("final_pop_count", pop_cnt, 7);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
